multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Main state sequencer for the multi-cycle MIPS CPU.
- Generates the 3-bit `state` code that the control decode LUT consumes. The LUT turns instruction plus state into datapath controls; this block turns instruction plus handshakes into state.
- Decodes each instruction's class once in ID and walks that class's state path. It also produces the fetch strobes, a retired-instruction counter and an illegal-instruction pulse.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all flops rise on posedge clk.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  instruction[31:26] from the IR; stable from ID onward.
- funct  input  6  instruction[5:0] from the IR.
- mem_ready  input  1  data memory has completed the current access.
- run  input  1  permits starting a new instruction.
- state  output  3  current state: ID=3'd0, IF=3'd1, EXEC=3'd2, MEM=3'd3, WB=3'd4.
- ir_we  output  1  latch the IR this cycle.
- pc_inc  output  1  write PC+4 this cycle.
- instr_done  output  1  one-cycle pulse in an instruction's final state.
- illegal  output  1  one-cycle pulse when an unsupported instruction is decoded.
- instr_count  output  CNT_W  number of retired instructions.

Behaviour:
- Reset (async, immediate): state=IF, class register cleared, instr_count=0. Combinational outputs follow from state=IF: ir_we=pc_inc=run, instr_done=0, illegal=0. Reset mid-instruction abandons it; no instr_done is produced.
- IF:
  - run=1: ir_we=1, pc_inc=1, next state ID.
  - run=0: hold IF, ir_we=pc_inc=0.
  - run is sampled only in IF; an instruction already in progress always completes.
- ID: the opcode/funct class is registered at the ID->next edge; later states use the registered class only. State paths after ID:
  - LW: EXEC, MEM, WB.
  - SW: EXEC, MEM.
  - J: returns straight to IF (final state is ID).
  - R-type ADD/SUB/SLT (funct 100000/100010/101010): EXEC, WB.
  - JR (funct 001000): EXEC.
  - JAL: EXEC, MEM.
  - BEQ/BNE: EXEC, MEM, WB.
  - ADDI/XORI: EXEC, WB.
- Illegal instruction (any other opcode, or any other funct for R-type):
  - illegal=1 in ID, then next state IF.
  - instr_done=0 and the counter does not increment; the instruction is treated as a NOP.
- MEM wait states:
  - For LW and SW, MEM holds while mem_ready=0 and advances on the first cycle with mem_ready=1.
  - For JAL and BEQ/BNE, mem_ready is ignored and MEM lasts one cycle.
- Final state:
  - instr_done=1 combinationally in the final state of each path, in the cycle the transition to IF occurs. This is WB, MEM (SW/JAL), EXEC (JR) or ID (J).
  - For a final MEM under SW, instr_done is qualified by mem_ready.
- Counter: instr_count increments on the same edge as instr_done. It wraps from 2^CNT_W-1 to 0.
- Unused encodings (3'd5-3'd7): next state IF, no pulses. This state is only reachable on SEU.
- Latency: minimum 2 cycles (J); LW takes 5+N cycles, where N = cycles with mem_ready low.

Decomposition:
- Shared package `mips_defs`:
  - opcode constants: LW, SW, J, RTYPE, JAL, BEQ, BNE, XORI, ADDI.
  - funct constants: ADD, SUB, SLT, JR.
  - state encodings: ID, IF, EXEC, MEM, WB.
  - instruction-class enum.
- One natural sub-module, `multicycle_instr_class`: a combinational opcode/funct-to-class decoder that also flags illegal encodings. The LUT can reuse it.

Test Plan:
- LW with mem_ready low for 2 MEM cycles -> state sequence 1,0,2,3,3,3,4,1; instr_done only in the WB cycle; instr_count 0->1.
- Back-to-back J, ADD (funct 100000), SW (mem_ready=1), JR -> states 1,0 | 1,0,2,4 | 1,0,2,3 | 1,0,2; four instr_done pulses; instr_count=4; ir_we=pc_inc=1 exactly in each IF cycle.
- opcode=6'b111111, then R-type with funct=6'b000000 -> each runs 1,0,1 with illegal=1 in the ID cycle; instr_done never asserts; instr_count unchanged.
- run dropped during LW EXEC -> LW completes through WB with instr_done=1; state then holds 1 with ir_we=0 until run=1.
- reset asserted asynchronously mid-EXEC of BEQ (not at a clock edge) -> state=1 and instr_count=0 before the next posedge; no instr_done pulse.
- CNT_W=4, run 16 ADDI instructions -> instr_count goes 15->0 on the 16th retirement.

Source files
------------

// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared opcode/funct constants, state encodings and instruction classes
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ST_ID   = 3'd0,
    ST_IF   = 3'd1,
    ST_EXEC = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE = 4'd0,
    CL_LW   = 4'd1,
    CL_SW   = 4'd2,
    CL_J    = 4'd3,
    CL_RALU = 4'd4,
    CL_JR   = 4'd5,
    CL_JAL  = 4'd6,
    CL_BR   = 4'd7,
    CL_IMM  = 4'd8
  } instr_class_t;

endpackage

// File: rtl/multicycle_instr_class.sv
// rtl/multicycle_instr_class.sv - combinational opcode/funct to instruction-class decoder
module multicycle_instr_class
  import mips_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] instr_class,
  output logic       illegal
);

  instr_class_t cls;

  always_comb begin
    cls = CL_NONE;
    case (opcode)
      OP_LW:          cls = CL_LW;
      OP_SW:          cls = CL_SW;
      OP_J:           cls = CL_J;
      OP_JAL:         cls = CL_JAL;
      OP_BEQ, OP_BNE: cls = CL_BR;
      OP_ADDI,
      OP_XORI:        cls = CL_IMM;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_SLT: cls = CL_RALU;
          FN_JR:                  cls = CL_JR;
          default:                cls = CL_NONE;
        endcase
      end
      default:        cls = CL_NONE;
    endcase
  end

  // Every supported encoding maps to a real class, so NONE doubles as the illegal flag.
  assign instr_class = cls;
  assign illegal     = (cls == CL_NONE);

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle MIPS state sequencer with fetch strobes and retire counter
module multicycle_sequencer
  import mips_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  input  logic             run,
  output logic [2:0]       state,
  output logic             ir_we,
  output logic             pc_inc,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t       state_q, state_d;
  instr_class_t class_q, dec_class;
  logic [3:0]   dec_class_raw;
  logic         dec_illegal;

  multicycle_instr_class u_class (
    .opcode      (opcode),
    .funct       (funct),
    .instr_class (dec_class_raw),
    .illegal     (dec_illegal)
  );

  assign dec_class = instr_class_t'(dec_class_raw);
  assign state     = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IF;
      class_q     <= CL_NONE;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      // The class is captured once on leaving ID; later states ignore the live IR.
      if (state_q == ST_ID)
        class_q <= dec_class;
      if (instr_done)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = ST_IF;
    ir_we      = 1'b0;
    pc_inc     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_IF: begin
        ir_we   = run;
        pc_inc  = run;
        state_d = run ? ST_ID : ST_IF;
      end
      ST_ID: begin
        if (dec_illegal)
          illegal = 1'b1;
        else if (dec_class == CL_J)
          instr_done = 1'b1;
        else
          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (class_q)
          CL_LW, CL_SW, CL_JAL, CL_BR: state_d = ST_MEM;
          CL_RALU, CL_IMM:             state_d = ST_WB;
          CL_JR:                       instr_done = 1'b1;
          default:                     state_d = ST_IF;
        endcase
      end
      ST_MEM: begin
        case (class_q)
          CL_LW:   state_d = mem_ready ? ST_WB : ST_MEM;
          CL_SW: begin
            if (mem_ready)
              instr_done = 1'b1;
            else
              state_d = ST_MEM;
          end
          CL_JAL:  instr_done = 1'b1;
          CL_BR:   state_d = ST_WB;
          default: state_d = ST_IF;
        endcase
      end
      ST_WB:   instr_done = 1'b1;
      default: state_d = ST_IF;
    endcase
  end

endmodule
